// File: rtl/branch_resolver.sv
// Branch condition unit: compares WIDTH-bit operands, flags mispredicts against pred_taken, and passes the branch tag through. The result appears 1 cycle after capture.
// It has a single-entry valid/ready output slot, refilled on drain without a bubble; flush kills the slot. Macro BRANCH_STATS_EN adds saturating counters.
module branch_resolver #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  input  logic [2:0]           compare_mode,
  input  logic                 pred_taken,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 taken,
  output logic                 mispredict,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam logic [2:0] MODE_NULL = 3'd0;
  localparam logic [2:0] MODE_BEQ  = 3'd1;
  localparam logic [2:0] MODE_BNE  = 3'd2;
  localparam logic [2:0] MODE_BLTZ = 3'd3;
  localparam logic [2:0] MODE_BGTZ = 3'd4;
  localparam logic [2:0] MODE_BLEZ = 3'd5;
  localparam logic [2:0] MODE_BGEZ = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

  logic                 out_valid_q, out_valid_d;
  logic                 taken_q, taken_d;
  logic                 mispredict_q, mispredict_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
  logic                 cond, capture, neg, zero;

  assign neg  = in0[WIDTH-1];
  assign zero = (in0 == '0);

  always_comb begin
    cond = 1'b0;
    case (compare_mode)
      MODE_BEQ:  cond = (in0 == in1);
      MODE_BNE:  cond = (in0 != in1);
      MODE_BLTZ: cond = neg;
      MODE_BGTZ: cond = !neg && !zero;
      MODE_BLEZ: cond = neg || zero;
      MODE_BGEZ: cond = !neg;
      default:   cond = 1'b0;
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    out_tag_d    = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d  = 1'b1;
      taken_d      = cond;
      mispredict_d = cond ^ pred_taken;
      out_tag_d    = in_tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign taken      = taken_q;
  assign mispredict = mispredict_q;
  assign out_tag    = out_tag_q;

`ifdef BRANCH_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
  logic                 counted;

  // NULL and reserved codes are not real branches and stay out of the statistics
  assign counted = capture && (compare_mode != MODE_NULL) && (compare_mode != MODE_RSVD);

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (counted && !(&branch_count_q))
      branch_count_d = branch_count_q + CNT_ONE;
    if (counted && (cond != pred_taken) && !(&mispredict_count_q))
      mispredict_count_d = mispredict_count_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule
